// File: rtl/rsa_mul_pkg.sv
// Shared constants, state encoding and address-sizing helper for the RSA Box
// multiplier peripheral.
package rsa_mul_pkg;

  localparam logic [1:0] REG_A   = 2'b00;
  localparam logic [1:0] REG_B   = 2'b01;
  localparam logic [1:0] REG_P   = 2'b10;
  localparam logic [1:0] REG_CSR = 2'b11;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int CTRL_START = 0;
  localparam int IRQ_EN_BIT = 0;

  typedef enum logic {
    IDLE,
    RUN
  } mul_state_t;

  // Word-index width for a region of n entries: max(1, clog2(n)).
  function automatic int idx_width(input int n_entries);
    return (n_entries <= 2) ? 1 : $clog2(n_entries);
  endfunction

endpackage

// File: rtl/rsa_mul_if.sv
// Memory-mapped host bus of the multiplier: select/write strobe, region+index
// address, write data and registered read data.
interface rsa_mul_if #(
  parameter int ADDR_W = 5
);
  logic              chipselect;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data1;
  logic [31:0]       bitsOut1;

  modport master (output chipselect, write, address, data1, input bitsOut1);
  modport slave  (input chipselect, write, address, data1, output bitsOut1);
endinterface

// File: rtl/rsa_shift_add_core.sv
// Radix-2 shift-add multiplier core: one multiplier bit per clock, full
// 2*OP_W-bit product presented alongside a one-cycle done_pulse.
module rsa_shift_add_core
  import rsa_mul_pkg::*;
#(
  parameter int OP_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done_pulse,
  output logic [2*OP_W-1:0] product
);

  localparam int              CNT_W    = $clog2(OP_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

  mul_state_t         state_q, state_d;
  logic [2*OP_W-1:0]  acc_q, acc_d;
  logic [2*OP_W-1:0]  mcand_q, mcand_d;
  logic [OP_W-1:0]    mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*OP_W-1:0]  acc_sum;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    done_pulse = 1'b0;
    acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          acc_d    = '0;
          mcand_d  = {{OP_W{1'b0}}, a};
          mplier_d = b;
          cnt_d    = CNT_LAST;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          state_d    = IDLE;
          done_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The last RUN cycle's sum is the committed product, so it is taken
  // combinationally rather than one cycle late from acc_q.
  assign product = acc_sum;
  assign busy    = (state_q == RUN);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its peers.
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rsa_mul_unit.sv
// RSA Box multiplier peripheral: bus decode, operand/product word registers,
// CTRL/STATUS CSR. Define RSA_MUL_IRQ_EN for the irq port and IRQ_EN register.
module rsa_mul_unit
  import rsa_mul_pkg::*;
#(
  parameter int OP_W   = 128,
  parameter int ADDR_W = 2 + idx_width(2 * (OP_W / 32))
) (
  input  logic      clk,
  input  logic      reset,
  rsa_mul_if.slave  bus
`ifdef RSA_MUL_IRQ_EN
  ,
  output logic      irq
`endif
);

  localparam int N_WORDS = OP_W / 32;
  localparam int IDX_W   = ADDR_W - 2;
  localparam int A_IW    = idx_width(N_WORDS);
  localparam int P_IW    = idx_width(2 * N_WORDS);

  localparam logic [IDX_W:0]   A_LIMIT      = (IDX_W + 1)'(N_WORDS);
  localparam logic [IDX_W:0]   P_LIMIT      = (IDX_W + 1)'(2 * N_WORDS);
  localparam logic [IDX_W-1:0] CSR_CTRL_IDX = '0;

  if (OP_W < 32 || (OP_W % 32) != 0) begin : g_bad_op_w
    $error("rsa_mul_unit: OP_W must be a multiple of 32 and at least 32");
  end
  if (ADDR_W != 2 + idx_width(2 * N_WORDS)) begin : g_bad_addr_w
    $error("rsa_mul_unit: ADDR_W must equal 2 + max(1, clog2(2*N_WORDS))");
  end

  logic [N_WORDS-1:0][31:0]   a_q, a_d;
  logic [N_WORDS-1:0][31:0]   b_q, b_d;
  logic [2*N_WORDS-1:0][31:0] p_q, p_d;
  logic                       done_q, done_d;
  logic [31:0]                rdata_q, rdata_d;

  logic [1:0]        region;
  logic [IDX_W-1:0]  idx;
  logic [A_IW-1:0]   a_idx;
  logic [P_IW-1:0]   p_idx;
  logic              a_in_range, p_in_range;
  logic              wr_acc, rd_acc;
  logic [31:0]       status;

  logic              core_start, core_busy, core_done;
  logic [2*OP_W-1:0] core_product;

`ifdef RSA_MUL_IRQ_EN
  localparam logic [IDX_W-1:0] CSR_IRQ_IDX = IDX_W'(1);
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;
`endif

  assign region     = bus.address[ADDR_W-1 -: 2];
  assign idx        = bus.address[IDX_W-1:0];
  assign a_idx      = idx[A_IW-1:0];
  assign p_idx      = idx[P_IW-1:0];
  assign a_in_range = ({1'b0, idx} < A_LIMIT);
  assign p_in_range = ({1'b0, idx} < P_LIMIT);
  assign wr_acc     = bus.chipselect & bus.write;
  assign rd_acc     = bus.chipselect & ~bus.write;

  always_comb begin
    status             = '0;
    status[STAT_BUSY]  = core_busy;
    status[STAT_DONE]  = done_q;
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    done_d     = done_q;
    rdata_d    = rdata_q;
    core_start = 1'b0;
`ifdef RSA_MUL_IRQ_EN
    irq_en_d   = irq_en_q;
`endif

    if (wr_acc) begin
      unique case (region)
        REG_A: if (!core_busy && a_in_range) begin
          a_d[a_idx] = bus.data1;
          done_d     = 1'b0;
        end
        REG_B: if (!core_busy && a_in_range) begin
          b_d[a_idx] = bus.data1;
          done_d     = 1'b0;
        end
        REG_CSR: begin
          if (idx == CSR_CTRL_IDX && bus.data1[CTRL_START] && !core_busy) begin
            core_start = 1'b1;
            done_d     = 1'b0;
          end
`ifdef RSA_MUL_IRQ_EN
          if (idx == CSR_IRQ_IDX) irq_en_d = bus.data1[IRQ_EN_BIT];
`endif
        end
        default: ;
      endcase
    end

    // Completion only happens while busy, when operand writes and starts are
    // locked out, so it never races a done-clearing write.
    if (core_done) begin
      p_d    = core_product;
      done_d = 1'b1;
    end

    if (rd_acc) begin
      rdata_d = '0;
      unique case (region)
        REG_A:   if (a_in_range) rdata_d = a_q[a_idx];
        REG_B:   if (a_in_range) rdata_d = b_q[a_idx];
        REG_P:   if (p_in_range) rdata_d = p_q[p_idx];
        REG_CSR: begin
          if (idx == CSR_CTRL_IDX) rdata_d = status;
`ifdef RSA_MUL_IRQ_EN
          if (idx == CSR_IRQ_IDX) rdata_d[IRQ_EN_BIT] = irq_en_q;
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef RSA_MUL_IRQ_EN
  assign irq_d = done_q & irq_en_q;
  assign irq   = irq_q;
`endif

  rsa_shift_add_core #(
    .OP_W (OP_W)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .start      (core_start),
    .a          (a_q),
    .b          (b_q),
    .busy       (core_busy),
    .done_pulse (core_done),
    .product    (core_product)
  );

  assign bus.bitsOut1 = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the operand and product word arrays are cleared on reset so an
      // aborted run leaves no stale data visible; this keeps them in flops.
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
`ifdef RSA_MUL_IRQ_EN
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
`ifdef RSA_MUL_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

endmodule
